// File: rtl/alu_request_scheduler.sv
// Shares one combinational 4-bit ALU between two requesters.
// Round-robin grant, settle-timed capture, valid/ready response.
module alu_request_scheduler #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,
  output logic             alu_s1,
  output logic             alu_s0,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  input  logic [4:0]       alu_sum,
  input  logic [3:0]       alu_and,
  input  logic             alu_eq,
  input  logic             alu_gt,
  input  logic             alu_lt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [1:0]       rsp_op,
  output logic [4:0]       rsp_data,
  output logic [2:0]       rsp_flags,
  output logic             rsp_cmp_err,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [3:0] SETTLE =
    (SETTLE_CYCLES < 1) ? 4'd1 : 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESPOND
  } state_t;

  state_t     state, state_nx;
  logic       ptr;
  logic       id_q;
  logic [3:0] cnt;
  logic       accept;
  logic       sel_id;
  logic [1:0] sel_op;
  logic [3:0] sel_a;
  logic [3:0] sel_b;
  logic       last_tick;
  logic [4:0] fmt_data;
  logic [2:0] fmt_flags;
  logic       fmt_err;

  always_comb begin
    state_nx   = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state)
      IDLE: begin
        req0_ready = req0_valid && (!req1_valid || !ptr);
        req1_ready = req1_valid && !req0_ready;
        if (req0_ready || req1_ready) state_nx = ISSUE;
      end
      ISSUE:   if (last_tick) state_nx = RESPOND;
      RESPOND: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign accept    = req0_ready || req1_ready;
  assign sel_id    = req1_ready;
  assign sel_op    = sel_id ? req1_op : req0_op;
  assign sel_a     = sel_id ? req1_a : req0_a;
  assign sel_b     = sel_id ? req1_b : req0_b;
  assign last_tick = (cnt == 4'd1);
  assign busy      = (state != IDLE);

  // Result word as seen by the consumer, keyed by the held opcode
  always_comb begin
    fmt_data  = '0;
    fmt_flags = '0;
    fmt_err   = 1'b0;
    unique case ({alu_s1, alu_s0})
      2'b00, 2'b01: fmt_data = alu_sum;
      2'b10: begin
        fmt_flags = {alu_gt, alu_eq, alu_lt};
        fmt_err   = !$onehot({alu_gt, alu_eq, alu_lt});
      end
      2'b11:   fmt_data = {1'b0, alu_and};
      default: fmt_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr         <= 1'b0;
      id_q        <= 1'b0;
      cnt         <= '0;
      alu_s1      <= 1'b0;
      alu_s0      <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_op      <= '0;
      rsp_data    <= '0;
      rsp_flags   <= '0;
      rsp_cmp_err <= 1'b0;
      op_count    <= '0;
    end else begin
      if (state == IDLE && accept) begin
        {alu_s1, alu_s0} <= sel_op;
        alu_a            <= sel_a;
        alu_b            <= sel_b;
        id_q             <= sel_id;
        ptr              <= ~sel_id;
        cnt              <= SETTLE;
      end
      if (state == ISSUE) begin
        cnt <= cnt - 4'd1;
        if (last_tick) begin
          rsp_valid   <= 1'b1;
          rsp_id      <= id_q;
          rsp_op      <= {alu_s1, alu_s0};
          rsp_data    <= fmt_data;
          rsp_flags   <= fmt_flags;
          rsp_cmp_err <= fmt_err;
        end
      end
      if (state == RESPOND && rsp_ready) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_request_scheduler.sv
// Randomized bench for alu_request_scheduler with a cycle-timed
// transaction model and a behavioural ALU.
module tb_alu_request_scheduler;

  localparam int S  = 3;
  localparam int CW = 8;

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } req_t;

  typedef struct packed {
    logic       id;
    logic [1:0] op;
    logic [4:0] data;
    logic [2:0] flags;
    logic       err;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [1:0]    req0_op = '0, req1_op = '0;
  logic [3:0]    req0_a = '0, req0_b = '0;
  logic [3:0]    req1_a = '0, req1_b = '0;
  logic          alu_s1, alu_s0;
  logic [3:0]    alu_a, alu_b;
  logic [4:0]    alu_sum;
  logic [3:0]    alu_and;
  logic          alu_eq, alu_gt, alu_lt;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_id;
  logic [1:0]    rsp_op;
  logic [4:0]    rsp_data;
  logic [2:0]    rsp_flags;
  logic          rsp_cmp_err;
  logic          busy;
  logic [CW-1:0] op_count;
  logic          fault = 1'b0;

  alu_request_scheduler #(
    .SETTLE_CYCLES(S),
    .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_s1(alu_s1), .alu_s0(alu_s0),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_sum(alu_sum), .alu_and(alu_and),
    .alu_eq(alu_eq), .alu_gt(alu_gt), .alu_lt(alu_lt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_op(rsp_op), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_cmp_err(rsp_cmp_err),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; fault forces two compare flags high
  assign alu_sum = alu_s0 ? ({1'b0, alu_a} - {1'b0, alu_b})
                          : ({1'b0, alu_a} + {1'b0, alu_b});
  assign alu_and = alu_a & alu_b;
  assign alu_gt  = (alu_a > alu_b) || fault;
  assign alu_eq  = (alu_a == alu_b) || fault;
  assign alu_lt  = (alu_a < alu_b);

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic rsp_t ref_rsp(logic id, req_t r, logic f);
    rsp_t x;
    int a, b, gt, eq, lt;
    a = int'(r.a);
    b = int'(r.b);
    x = '0;
    x.id = id;
    x.op = r.op;
    case (r.op)
      2'd0: x.data = 5'((a + b) % 32);
      2'd1: x.data = 5'((a - b + 32) % 32);
      2'd2: begin
        gt = ((a > b) || f) ? 1 : 0;
        eq = ((a == b) || f) ? 1 : 0;
        lt = (a < b) ? 1 : 0;
        x.flags = {gt[0], eq[0], lt[0]};
        x.err = ((gt + eq + lt) != 1);
      end
      default: x.data = 5'(a & b);
    endcase
    return x;
  endfunction

  function automatic req_t mk(int op, int a, int b);
    req_t r;
    r.op = 2'(op);
    r.a = 4'(a);
    r.b = 4'(b);
    return r;
  endfunction

  // Model of what the scheduler should be doing
  bit         m_idle, m_has, m_ptr, m_rsp_chk;
  int         m_due, m_cnt, m_total;
  rsp_t       m_pend, m_rsp;
  logic [1:0] m_sel;
  logic [3:0] m_a, m_b;
  int         cyc_n = 0;

  // Inputs as they stood at the last rising edge
  logic pv0 = 0, pv1 = 0, pr0 = 0, pr1 = 0;
  logic prdy = 0, prst = 0, pfire = 0;
  req_t p0 = '0, p1 = '0;

  req_t q0[$];
  req_t q1[$];
  bit   gen = 0, hide_en = 0, rst_req = 1;
  int   rdy_mode = 1;
  bit   inflight = 0;
  logic if_id;
  req_t if_req;

  task automatic model_edge();
    logic g;
    bit acc;
    req_t r;
    acc = 0;
    g = 0;
    if (!prst) begin
      m_idle = 1; m_has = 0; m_ptr = 0; m_cnt = 0;
      m_sel = 0; m_a = 0; m_b = 0; m_rsp = '0; m_rsp_chk = 1;
    end else if (m_idle) begin
      if (pv0 && (!pv1 || !m_ptr)) begin g = 0; acc = 1; end
      else if (pv1) begin g = 1; acc = 1; end
      if (acc) begin
        r = g ? p1 : p0;
        m_idle = 0;
        m_due = cyc_n + S;
        m_sel = r.op; m_a = r.a; m_b = r.b;
        m_ptr = !g;
        m_pend = ref_rsp(g, r, fault);
      end
    end else if (!m_has) begin
      if (cyc_n == m_due) begin
        m_has = 1; m_rsp = m_pend; m_rsp_chk = 1;
      end
    end else if (prdy) begin
      m_has = 0; m_idle = 1; m_rsp_chk = 0;
      m_cnt = (m_cnt + 1) % (1 << CW);
      m_total++;
    end
  endtask

  // Requester side: retire on handshake, retry after a reset
  task automatic bookkeep();
    if (!prst) begin
      if (inflight) begin
        if (if_id) q1.push_front(if_req);
        else       q0.push_front(if_req);
        inflight = 0;
      end
    end else begin
      if (pv0 && pr0) begin
        if_req = q0.pop_front(); if_id = 0; inflight = 1;
      end else if (pv1 && pr1) begin
        if_req = q1.pop_front(); if_id = 1; inflight = 1;
      end
      if (pfire) inflight = 0;
    end
  endtask

  task automatic check_regs();
    chk("busy", busy, !m_idle);
    chk("rsp_valid", rsp_valid, m_has);
    chk("op_count", op_count, m_cnt);
    chk("alu_sel", {alu_s1, alu_s0}, m_sel);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    if (m_rsp_chk) begin
      chk("rsp_id", rsp_id, m_rsp.id);
      chk("rsp_op", rsp_op, m_rsp.op);
      chk("rsp_data", rsp_data, m_rsp.data);
      chk("rsp_flags", rsp_flags, m_rsp.flags);
      chk("rsp_cmp_err", rsp_cmp_err, m_rsp.err);
    end
  endtask

  task automatic drive();
    bit h0, h1;
    if (gen) begin
      if (q0.size() < 2 && $urandom_range(0, 3) == 0)
        q0.push_back(mk($urandom_range(0, 3), $urandom_range(0, 15),
                        $urandom_range(0, 15)));
      if (q1.size() < 2 && $urandom_range(0, 3) == 0)
        q1.push_back(mk($urandom_range(0, 3), $urandom_range(0, 15),
                        $urandom_range(0, 15)));
    end
    h0 = hide_en && ($urandom_range(0, 4) == 0);
    h1 = hide_en && ($urandom_range(0, 4) == 0);
    rst_n = !rst_req;
    req0_valid = (q0.size() > 0) && !h0;
    req1_valid = (q1.size() > 0) && !h1;
    {req0_op, req0_a, req0_b} = (q0.size() > 0) ? q0[0] : '0;
    {req1_op, req1_a, req1_b} = (q1.size() > 0) ? q1[0] : '0;
    rsp_ready = (rdy_mode == 0) ? ($urandom_range(0, 9) < 7)
                                : (rdy_mode == 1);
  endtask

  task automatic check_ready();
    logic e0, e1;
    e0 = m_idle && req0_valid && (!req1_valid || !m_ptr);
    e1 = m_idle && req1_valid && !e0;
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
  endtask

  task automatic cyc();
    @(negedge clk);
    cyc_n++;
    model_edge();
    bookkeep();
    check_regs();
    drive();
    #1;
    check_ready();
    pv0 = req0_valid; pv1 = req1_valid;
    p0 = {req0_op, req0_a, req0_b};
    p1 = {req1_op, req1_a, req1_b};
    pr0 = req0_ready; pr1 = req1_ready;
    prdy = rsp_ready; prst = rst_n;
    pfire = rsp_valid && rsp_ready;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || !m_idle || inflight)
           && n < 300) begin
      cyc();
      n++;
    end
    chk("drain_done", n < 300, 1);
  endtask

  initial begin
    int n, start;
    rst_req = 1;
    repeat (2) cyc();
    rst_req = 0;
    rdy_mode = 1;

    // Both requesters loaded: grants alternate starting with 0
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(i, 3 + i, 9 - i));
      q1.push_back(mk(3 - i, 12 - i, i));
    end
    drain();

    // Add, compare, AND operand patterns
    q0.push_back(mk(0, 4'b1101, 4'b0111));
    q1.push_back(mk(2, 4'b1111, 4'b1110));
    q1.push_back(mk(3, 4'b0111, 4'b1110));
    q0.push_back(mk(1, 4'b0010, 4'b0101));
    drain();

    // Held-off consumer, second request waiting behind it
    rdy_mode = 2;
    q0.push_back(mk(1, 9, 4));
    q1.push_back(mk(0, 15, 15));
    n = 0;
    while (!m_has && n < 20) begin cyc(); n++; end
    chk("bp_rsp_seen", m_has, 1);
    repeat (5) cyc();
    rdy_mode = 1;
    drain();

    // Reset while the ALU is settling; request is presented again
    q0.push_back(mk(0, 7, 8));
    n = 0;
    while (m_idle && n < 20) begin cyc(); n++; end
    chk("mid_accept", m_idle, 0);
    rst_req = 1;
    cyc();
    rst_req = 0;
    cyc();
    chk("mid_reset_cnt", op_count, 0);
    drain();

    // Corrupted comparator flags
    fault = 1;
    q1.push_back(mk(2, 5, 5));
    q1.push_back(mk(2, 9, 2));
    q0.push_back(mk(2, 1, 7));
    q0.push_back(mk(0, 6, 6));
    drain();
    fault = 0;

    // Random traffic long enough to wrap op_count
    gen = 1; hide_en = 1; rdy_mode = 0;
    start = m_total;
    n = 0;
    while (m_total - start < 270 && n < 6000) begin cyc(); n++; end
    chk("wrap_run", (m_total - start) >= 270, 1);
    gen = 0; hide_en = 0; rdy_mode = 1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
